// File: rtl/board_b_tile_layer_gen.sv
// rtl/board_b_tile_layer_gen.sv - scrolling 8x8 tile layer: VRAM, shared-ROM tile fetch, pixel shifter
// Fetch runs one tile ahead of display; tile boundaries are taken in display order so NL keeps the lead time.
module board_b_tile_layer_gen #(
   parameter int MAP_W_LOG2   = 6,
   parameter int MAP_H_LOG2   = 6,
   parameter int CODE_W       = 14,
   parameter int BPP          = 4,
   parameter int LATCH_ON_VBL = 1
) (
   input  logic                           CLK_32M,
   input  logic                           RESET_N,
   input  logic                           CE_PIX,
   input  logic [15:0]                    DIN,
   output logic [15:0]                    DOUT,
   input  logic [MAP_W_LOG2+MAP_H_LOG2:0] A,
   input  logic [1:0]                     BYTE_SEL,
   input  logic                           WR,
   input  logic                           VSCK,
   input  logic                           HSCK,
   input  logic                           NL,
   input  logic                           VBLANK,
   input  logic [8:0]                     VE,
   input  logic [9:0]                     HE,
   output logic                           GFX_REQ,
   output logic [CODE_W+2:0]              GFX_ADDR,
   input  logic                           GFX_ACK,
   input  logic [8*BPP-1:0]               GFX_DATA,
   output logic [BPP-1:0]                 BIT,
   output logic [3:0]                     COL,
   output logic                           CP15,
   output logic                           CP8,
   output logic                           UNDERRUN
);
   localparam int AW = MAP_W_LOG2 + MAP_H_LOG2 + 1;
   localparam int RW = 8 * BPP;
   localparam logic [MAP_W_LOG2-1:0] COL_ONE = 1;

   typedef enum logic [2:0] {S_IDLE, S_RD_CODE, S_RD_ATTR, S_REQ, S_READY} state_t;
   state_t state_q, state_d;

   logic [15:0]            vram [0:(1<<AW)-1];
   logic [15:0]            rd_q, dout_q;
   logic [AW-1:0]          rd_addr;
   logic [9:0]             h_pend_q, h_pend_d, scroll_h_q, scroll_h_d;
   logic [8:0]             v_pend_q, v_pend_d, scroll_v_q, scroll_v_d;
   logic                   vbl_q, vbl_d;
   logic [AW-2:0]          idx_q, idx_d;
   logic [2:0]             vrow_q, vrow_d;
   logic                   hrev_q, hrev_d;
   logic [CODE_W+2:0]      gfx_addr_q, gfx_addr_d;
   logic [RW-1:0]          data_q, data_d, shreg_q, shreg_d, data_rev;
   logic [5:0]             attr_q, attr_d, tile_attr_q, tile_attr_d;
   logic [BPP-1:0]         bit_q, bit_d;
   logic [3:0]             col_q, col_d;
   logic                   cp15_q, cp15_d, cp8_q, cp8_d, underrun_q, underrun_d;
   logic [9:0]             hx;
   logic [8:0]             vy;
   logic [2:0]             pix;
   logic [MAP_W_LOG2-1:0]  cur_col, next_col;
   logic                   load;
   logic                   unused_ok;

   assign hx       = (HE ^ {10{NL}}) + scroll_h_q;
   assign vy       = (VE ^ {9{NL}}) + scroll_v_q;
   assign pix      = hx[2:0] ^ {3{NL}};
   assign cur_col  = hx[3 +: MAP_W_LOG2];
   assign next_col = NL ? cur_col - COL_ONE : cur_col + COL_ONE;
   assign load     = CE_PIX && (pix == 3'd7);
   assign rd_addr  = {idx_q, state_q != S_RD_CODE};
   assign unused_ok = ^{hx, vy, rd_q, DIN};

   always_ff @(posedge CLK_32M) begin
      if (WR && BYTE_SEL[0]) vram[A][7:0]  <= DIN[7:0];
      if (WR && BYTE_SEL[1]) vram[A][15:8] <= DIN[15:8];
      rd_q <= vram[rd_addr];
   end

   always_ff @(posedge CLK_32M or negedge RESET_N) begin
      if (!RESET_N) dout_q <= '0;
      else          dout_q <= vram[A];
   end

   // ROM row is pixel-packed, leftmost pixel in the top BPP bits.
   always_comb begin
      data_rev = '0;
      for (int i = 0; i < 8; i++) data_rev[i*BPP +: BPP] = data_q[(7-i)*BPP +: BPP];
   end

   always_comb begin
      state_d     = state_q;
      h_pend_d    = h_pend_q;
      v_pend_d    = v_pend_q;
      scroll_h_d  = scroll_h_q;
      scroll_v_d  = scroll_v_q;
      vbl_d       = VBLANK;
      idx_d       = idx_q;
      vrow_d      = vrow_q;
      hrev_d      = hrev_q;
      gfx_addr_d  = gfx_addr_q;
      data_d      = data_q;
      attr_d      = attr_q;
      shreg_d     = shreg_q;
      tile_attr_d = tile_attr_q;
      bit_d       = bit_q;
      col_d       = col_q;
      cp15_d      = cp15_q;
      cp8_d       = cp8_q;
      underrun_d  = underrun_q;

      if (HSCK && BYTE_SEL[0]) h_pend_d = DIN[9:0];
      if (VSCK && BYTE_SEL[0]) v_pend_d = DIN[8:0];
      if (LATCH_ON_VBL == 0) begin
         scroll_h_d = h_pend_d;
         scroll_v_d = v_pend_d;
      end else if (VBLANK && !vbl_q) begin
         scroll_h_d = h_pend_q;
         scroll_v_d = v_pend_q;
      end
      if (HSCK && BYTE_SEL == 2'b00) underrun_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (CE_PIX && pix == 3'd0) begin
               idx_d   = {vy[3 +: MAP_H_LOG2], next_col};
               vrow_d  = vy[2:0];
               state_d = S_RD_CODE;
            end
         end
         S_RD_CODE: state_d = S_RD_ATTR;
         S_RD_ATTR: begin
            hrev_d     = rd_q[15];
            gfx_addr_d = {rd_q[CODE_W-1:0], vrow_q ^ {3{rd_q[14]}}};
            state_d    = S_REQ;
         end
         S_REQ: begin
            if (GFX_ACK) begin
               data_d  = GFX_DATA;
               attr_d  = {rd_q[15], rd_q[14], rd_q[3:0]};
               state_d = S_READY;
            end
         end
         S_READY: state_d = S_READY;
         default: state_d = S_IDLE;
      endcase

      if (CE_PIX) begin
         bit_d   = shreg_q[RW-1 -: BPP];
         col_d   = tile_attr_q[3:0];
         cp15_d  = tile_attr_q[5];
         cp8_d   = tile_attr_q[4];
         shreg_d = shreg_q << BPP;
      end
      // A late tile is blanked and its fetch abandoned; the old attributes stay.
      if (load) begin
         if (state_q == S_READY) begin
            shreg_d     = (hrev_q ^ NL) ? data_rev : data_q;
            tile_attr_d = attr_q;
         end else begin
            shreg_d    = '0;
            underrun_d = 1'b1;
         end
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge CLK_32M or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= S_IDLE;
         h_pend_q    <= '0;
         v_pend_q    <= '0;
         scroll_h_q  <= '0;
         scroll_v_q  <= '0;
         vbl_q       <= 1'b0;
         idx_q       <= '0;
         vrow_q      <= '0;
         hrev_q      <= 1'b0;
         gfx_addr_q  <= '0;
         data_q      <= '0;
         attr_q      <= '0;
         shreg_q     <= '0;
         tile_attr_q <= '0;
         bit_q       <= '0;
         col_q       <= '0;
         cp15_q      <= 1'b0;
         cp8_q       <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_pend_q    <= h_pend_d;
         v_pend_q    <= v_pend_d;
         scroll_h_q  <= scroll_h_d;
         scroll_v_q  <= scroll_v_d;
         vbl_q       <= vbl_d;
         idx_q       <= idx_d;
         vrow_q      <= vrow_d;
         hrev_q      <= hrev_d;
         gfx_addr_q  <= gfx_addr_d;
         data_q      <= data_d;
         attr_q      <= attr_d;
         shreg_q     <= shreg_d;
         tile_attr_q <= tile_attr_d;
         bit_q       <= bit_d;
         col_q       <= col_d;
         cp15_q      <= cp15_d;
         cp8_q       <= cp8_d;
         underrun_q  <= underrun_d;
      end
   end

   assign DOUT     = dout_q;
   assign GFX_REQ  = (state_q == S_REQ);
   assign GFX_ADDR = gfx_addr_q;
   assign BIT      = bit_q;
   assign COL      = col_q;
   assign CP15     = cp15_q;
   assign CP8      = cp8_q;
   assign UNDERRUN = underrun_q;
endmodule

// File: tb/tb_board_b_tile_layer_gen.sv
// tb/tb_board_b_tile_layer_gen.sv - directed bench for board_b_tile_layer_gen
module tb_board_b_tile_layer_gen;
   logic        CLK_32M = 1'b0;
   logic        RESET_N = 1'b0;
   logic        CE_PIX = 1'b0;
   logic [15:0] DIN = '0;
   logic [15:0] DOUT;
   logic [12:0] A = '0;
   logic [1:0]  BYTE_SEL = '0;
   logic        WR = 1'b0, VSCK = 1'b0, HSCK = 1'b0, NL = 1'b0, VBLANK = 1'b0;
   logic [8:0]  VE = '0;
   logic [9:0]  HE = '0;
   logic        GFX_REQ;
   logic [16:0] GFX_ADDR;
   logic        GFX_ACK = 1'b0;
   logic [31:0] GFX_DATA = 32'h1234_5678;
   logic [3:0]  BIT, COL;
   logic        CP15, CP8, UNDERRUN;

   int n_checks = 0, n_err = 0;
   int tick_cnt = 0, wait_cnt = 0, req_tick = 0, t0 = 0;
   int ack_delay = 4;
   bit ack_en = 1'b1, req_seen = 1'b0;
   logic [16:0] req_addr = '0;
   logic [31:0] seq;
   logic [3:0]  c_col;
   logic        c15, c8;

   board_b_tile_layer_gen dut (
      .CLK_32M(CLK_32M), .RESET_N(RESET_N), .CE_PIX(CE_PIX), .DIN(DIN), .DOUT(DOUT),
      .A(A), .BYTE_SEL(BYTE_SEL), .WR(WR), .VSCK(VSCK), .HSCK(HSCK), .NL(NL),
      .VBLANK(VBLANK), .VE(VE), .HE(HE), .GFX_REQ(GFX_REQ), .GFX_ADDR(GFX_ADDR),
      .GFX_ACK(GFX_ACK), .GFX_DATA(GFX_DATA), .BIT(BIT), .COL(COL), .CP15(CP15),
      .CP8(CP8), .UNDERRUN(UNDERRUN)
   );

   always #5 CLK_32M = ~CLK_32M;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock; the ROM model answers a request after ack_delay cycles.
   task automatic tick();
      @(posedge CLK_32M);
      #1;
      tick_cnt++;
      GFX_ACK = 1'b0;
      if (GFX_REQ) begin
         if (!req_seen) begin
            req_seen = 1'b1;
            req_addr = GFX_ADDR;
            req_tick = tick_cnt;
         end
         if (ack_en) begin
            wait_cnt++;
            if (wait_cnt >= ack_delay) begin
               GFX_ACK  = 1'b1;
               wait_cnt = 0;
            end
         end
      end else begin
         wait_cnt = 0;
      end
   endtask

   task automatic pix();
      CE_PIX = 1'b1;
      tick();
      CE_PIX = 1'b0;
      repeat (3) tick();
      HE = HE + 10'd1;
   endtask

   // Preroll one tile, fetch at he0, then collect the eight pixels of the next tile.
   task automatic show_tile(input logic [9:0] he0);
      HE = he0 - 10'd8;
      repeat (8) pix();
      req_seen = 1'b0;
      req_tick = 0;
      t0 = tick_cnt;
      HE = he0;
      repeat (8) pix();
      seq = '0;
      for (int i = 0; i < 8; i++) begin
         pix();
         seq = {seq[27:0], BIT};
         if (i == 0) begin
            c_col = COL;
            c15   = CP15;
            c8    = CP8;
         end
      end
   endtask

   function automatic logic [12:0] waddr(input int row, input int col, input int sel);
      return 13'((row * 64 + col) * 2 + sel);
   endfunction

   task automatic vram_wr(input logic [12:0] addr, input logic [15:0] d, input logic [1:0] be);
      A = addr; DIN = d; BYTE_SEL = be; WR = 1'b1;
      tick();
      WR = 1'b0;
   endtask

   task automatic scr_wr_h(input logic [15:0] d);
      DIN = d; BYTE_SEL = 2'b01; HSCK = 1'b1;
      tick();
      HSCK = 1'b0;
   endtask

   task automatic vbl_pulse();
      VBLANK = 1'b1;
      repeat (2) tick();
      VBLANK = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      repeat (2) tick();
      RESET_N = 1'b1;
      tick();
   endtask

   initial begin
      RESET_N = 1'b0;
      for (int i = 0; i < 4; i++) begin
         GFX_ACK = ~GFX_ACK;
         @(posedge CLK_32M);
         #1;
      end
      check("rst_req", GFX_REQ, 0);
      check("rst_bit", BIT, 0);
      check("rst_underrun", UNDERRUN, 0);
      check("rst_addr", GFX_ADDR, 0);
      check("rst_col", COL, 0);
      RESET_N = 1'b1;
      GFX_ACK = 1'b1;
      @(posedge CLK_32M);
      #1;
      GFX_ACK = 1'b0;
      check("late_ack_req", GFX_REQ, 0);

      vram_wr(waddr(0, 0, 0), 16'h0005, 2'b11);
      vram_wr(waddr(0, 0, 1), 16'h8003, 2'b11);
      vram_wr(waddr(0, 1, 0), 16'h0009, 2'b11);
      vram_wr(waddr(0, 1, 1), 16'h0007, 2'b11);
      vram_wr(waddr(0, 2, 0), 16'h000A, 2'b11);
      vram_wr(waddr(0, 2, 1), 16'h000B, 2'b11);
      vram_wr(waddr(0, 63, 0), 16'h0011, 2'b11);
      vram_wr(waddr(0, 63, 1), 16'h000C, 2'b11);
      vram_wr(waddr(63, 0, 0), 16'hC005, 2'b11);
      vram_wr(waddr(63, 0, 1), 16'h8003, 2'b11);
      vram_wr(13'd100, 16'hAAAA, 2'b11);
      vram_wr(13'd100, 16'h5500, 2'b10);
      A = 13'd100;
      tick();
      check("dout_bytewr", DOUT, 16'h55AA);
      A = waddr(0, 0, 1);
      tick();
      check("dout_attr", DOUT, 16'h8003);

      show_tile(10'd504);
      check("req_latency", 32'(req_tick - t0), 3);
      check("basic_addr", req_addr, 17'h00028);
      check("basic_pix", seq, 32'h1234_5678);
      check("basic_col", c_col, 3);
      check("basic_cp15", c15, 1);
      check("basic_cp8", c8, 0);
      check("basic_underrun", UNDERRUN, 0);

      ack_en = 1'b0;
      show_tile(10'd504);
      check("ur_pix", seq, 0);
      check("ur_keep_col", c_col, 7);
      check("ur_sticky", UNDERRUN, 1);
      check("ur_req_abort", GFX_REQ, 0);
      ack_en = 1'b1;
      DIN = '0; BYTE_SEL = 2'b00; HSCK = 1'b1;
      tick();
      HSCK = 1'b0;
      check("ur_clear", UNDERRUN, 0);
      show_tile(10'd504);
      check("ur_recover_pix", seq, 32'h1234_5678);
      check("ur_recover_flag", UNDERRUN, 0);

      ack_en = 1'b0;
      HE = 10'd496;
      repeat (8) pix();
      pix();
      check("mid_req_up", GFX_REQ, 1);
      #2;
      RESET_N = 1'b0;
      #1;
      check("async_req_drop", GFX_REQ, 0);
      tick();
      RESET_N = 1'b1;
      ack_en = 1'b1;
      tick();

      vram_wr(waddr(0, 0, 0), 16'hC005, 2'b11);
      VE = 9'd1;
      show_tile(10'd504);
      check("vflip_addr", req_addr, 17'h0002E);
      check("hflip_pix", seq, 32'h8765_4321);
      NL = 1'b1;
      show_tile(10'd496);
      check("nl_addr", req_addr, 17'h00029);
      check("nl_pix", seq, 32'h1234_5678);
      NL = 1'b0;
      VE = 9'd0;
      vram_wr(waddr(0, 0, 0), 16'h0005, 2'b11);

      scr_wr_h(16'h0008);
      show_tile(10'd504);
      check("scr_pend_addr", req_addr, 17'h00028);
      check("scr_pend_col", c_col, 3);
      vbl_pulse();
      show_tile(10'd504);
      check("scr_vbl_addr", req_addr, 17'h00048);
      check("scr_vbl_col", c_col, 7);
      VBLANK = 1'b1; DIN = 16'h0010; BYTE_SEL = 2'b01; HSCK = 1'b1;
      tick();
      HSCK = 1'b0;
      tick();
      VBLANK = 1'b0;
      tick();
      show_tile(10'd504);
      check("scr_edge_addr", req_addr, 17'h00048);
      check("scr_edge_col", c_col, 7);
      vbl_pulse();
      show_tile(10'd504);
      check("scr_next_addr", req_addr, 17'h00050);
      check("scr_next_col", c_col, 11);

      scr_wr_h(16'h01F8);
      vbl_pulse();
      show_tile(10'd1016);
      check("wrap_c63_addr", req_addr, 17'h00088);
      check("wrap_c63_col", c_col, 12);
      show_tile(10'd0);
      check("wrap_c0_addr", req_addr, 17'h00028);
      check("wrap_c0_col", c_col, 3);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
